edge_distance_engine: RTL
=========================

EDGE_DISTANCE_ENGINE -- requirements
Module: edge_distance_engine

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to build the distance table; honoured only in IDLE.
REQ-004 SHALL have port node_count, input, 5, number of nodes N (0..16); sampled in the cycle start is accepted.
REQ-005 SHALL have port coord_addr, output, 8, shared read address driven to XMEM and YMEM.
REQ-006 SHALL have port x_q, input, 8, XMEM read data; valid one cycle after coord_addr is presented.
REQ-007 SHALL have port y_q, input, 8, YMEM read data; same timing as x_q.
REQ-008 SHALL have port dist_addr, output, 8, distance-memory write address {i[3:0], j[3:0]}.
REQ-009 SHALL have port dist_data, output, 9, Manhattan distance |xi-xj| + |yi-yj|.
REQ-010 SHALL have port dist_wren, output, 1, distance-memory write strobe, one cycle per pair.
REQ-011 SHALL have port busy, output, 1, high while a table build is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at the end of every accepted build.
REQ-013 SHALL have port err, output, 1, set at done when the latched N > 16; cleared on the next accepted start.

Function
REQ-014 SHALL implement states IDLE, RD_I, CAP_I, RD_J, WR_J and DONE.
REQ-015 IDLE transitions:
  - start=1 with 1<=N<=16: latch N, set i=0, go to RD_I.
  - start=1 with N=0 or N>16: latch N, go directly to DONE; err=(N>16).
REQ-016 RD_I: coord_addr={4'b0,i}; next state CAP_I.
REQ-017 CAP_I: register xi=x_q and yi=y_q; set j=0; next state RD_J.
REQ-018 RD_J: coord_addr={4'b0,j}; next state WR_J.
REQ-019 WR_J: dist_wren=1, dist_addr={i,j}, dist_data computed combinationally from xi, yi, x_q, y_q.
REQ-020 WR_J exit: if j<N-1, j++ and go to RD_J; else if i<N-1, i++ and go to RD_I; else go to DONE.
REQ-021 Arithmetic:
  - absolute differences are unsigned 8-bit;
  - sum is 9-bit and never saturates (maximum 510 = 9'h1FE);
  - diagonal pairs (i==j) are written naturally as 0.
REQ-022 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-023 busy=1 in every state except IDLE and DONE.
REQ-024 Build latency: N*(2+2N) busy cycles, then one DONE cycle; exactly N*N writes, row-major (i outer, j inner).
REQ-025 start while not in IDLE SHALL be ignored, with no effect on counters or on the latched N.
REQ-026 dist_wren SHALL be 0 in every state other than WR_J.
REQ-027 coord_addr SHALL hold its last value outside RD_I and RD_J.
REQ-028 dist_addr and dist_data are don't-care when dist_wren=0.
REQ-029 node_count changes after start is accepted SHALL NOT affect the build in progress.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL enter IDLE with: busy=0, done=0, err=0, dist_wren=0, coord_addr=0, i=j=0, xi=yi=0, latched N=0.
REQ-031 Reset mid-build SHALL abort the build in the next cycle with no further writes and no done pulse.
REQ-032 Reset SHALL take priority over start in the same cycle.

Verification
REQ-033 N=2, mem[0]=(3,4), mem[1]=(10,1), start pulse:
  - 4 writes, in order: {0x00:0, 0x01:10, 0x10:10, 0x11:0};
  - busy high for 12 cycles, done once, err=0.
REQ-034 N=2, mem[0]=(0,0), mem[1]=(255,255): dist[0x01]=dist[0x10]=9'h1FE.
REQ-035 N=0 start -> done in the next cycle, no dist_wren, err=0; N=17 start -> done in the next cycle, no writes, err=1.
REQ-036 N=16, random coords:
  - 256 writes, each matching a reference model, and dist[ij]==dist[ji];
  - busy for 544 cycles;
  - a second start pulse during the build is ignored.
REQ-037 N=4, reset asserted in the 7th busy cycle:
  - IDLE next cycle, no done, no writes after reset;
  - a following start with N=1 gives a single write {0x00:0} and done.

Source files
------------

// File: rtl/edge_distance_engine.sv
// Builds an N x N Manhattan distance table from coordinate memories XMEM/YMEM.
// Row-major walk: the row node is captured once, then every column node is streamed past it.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; N latched on an accepted start
// S_RD_I  | present row index i on coord_addr
// S_CAP_I | capture xi/yi from the memory read data
// S_RD_J  | present column index j on coord_addr
// S_WR_J  | write |xi-xj|+|yi-yj| to {i,j}, then step j, i or finish
// S_DONE  | one-cycle done pulse; err reflects the latched N
module edge_distance_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] node_count,
    output logic [7:0] coord_addr,
    input  logic [7:0] x_q,
    input  logic [7:0] y_q,
    output logic [7:0] dist_addr,
    output logic [8:0] dist_data,
    output logic       dist_wren,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_I,
        S_CAP_I,
        S_RD_J,
        S_WR_J,
        S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [4:0] r_n, w_n_nxt;
    logic [3:0] r_i, w_i_nxt;
    logic [3:0] r_j, w_j_nxt;
    logic [7:0] r_xi, w_xi_nxt;
    logic [7:0] r_yi, w_yi_nxt;
    logic [7:0] r_addr_hold;
    logic       r_err, w_err_nxt;

    logic [7:0] w_dx;
    logic [7:0] w_dy;
    logic       w_j_more;
    logic       w_i_more;

    assign w_j_more = (({1'b0, r_j} + 5'd1) < r_n);
    assign w_i_more = (({1'b0, r_i} + 5'd1) < r_n);

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_xi_nxt    = r_xi;
        w_yi_nxt    = r_yi;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_n_nxt   = node_count;
                    w_err_nxt = (node_count > 5'd16);
                    w_i_nxt   = 4'd0;
                    w_j_nxt   = 4'd0;
                    if (node_count == 5'd0 || node_count > 5'd16) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RD_I;
                    end
                end
            end
            S_RD_I: w_state_nxt = S_CAP_I;
            S_CAP_I: begin
                w_xi_nxt    = x_q;
                w_yi_nxt    = y_q;
                w_j_nxt     = 4'd0;
                w_state_nxt = S_RD_J;
            end
            S_RD_J: w_state_nxt = S_WR_J;
            S_WR_J: begin
                if (w_j_more) begin
                    w_j_nxt     = r_j + 4'd1;
                    w_state_nxt = S_RD_J;
                end else if (w_i_more) begin
                    w_i_nxt     = r_i + 4'd1;
                    w_state_nxt = S_RD_I;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_n         <= 5'd0;
            r_i         <= 4'd0;
            r_j         <= 4'd0;
            r_xi        <= 8'd0;
            r_yi        <= 8'd0;
            r_addr_hold <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_n         <= w_n_nxt;
            r_i         <= w_i_nxt;
            r_j         <= w_j_nxt;
            r_xi        <= w_xi_nxt;
            r_yi        <= w_yi_nxt;
            r_addr_hold <= coord_addr;
            r_err       <= w_err_nxt;
        end
    end

    // Address is live in the read states and frozen everywhere else.
    always_comb begin
        coord_addr = r_addr_hold;
        if (r_state == S_RD_I) begin
            coord_addr = {4'b0, r_i};
        end else if (r_state == S_RD_J) begin
            coord_addr = {4'b0, r_j};
        end
    end

    assign w_dx = (r_xi >= x_q) ? (r_xi - x_q) : (x_q - r_xi);
    assign w_dy = (r_yi >= y_q) ? (r_yi - y_q) : (y_q - r_yi);

    assign dist_data = {1'b0, w_dx} + {1'b0, w_dy};
    assign dist_addr = {r_i, r_j};
    assign dist_wren = (r_state == S_WR_J);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule
